// File: rtl/ysyx_23060061_rev_lookup.sv
// Reverse lookup table: maps a stored data value back to the key it was
// written with. Writes update by key or allocate (lowest free entry first,
// round-robin replacement when full). Lookups are answered one cycle later
// through a registered valid/ready response channel.
module ysyx_23060061_rev_lookup #(
    parameter int NR_ENTRY = 4,
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 32,
    localparam int IDX_LEN = $clog2(NR_ENTRY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                lk_valid,
    output logic                lk_ready,
    input  logic [DATA_LEN-1:0] lk_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic [KEY_LEN-1:0]  rsp_key,
    output logic [IDX_LEN-1:0]  rsp_idx,
    output logic [IDX_LEN:0]    count
);

    // Entry storage and replacement state
    logic [NR_ENTRY-1:0] r_valid;
    logic [KEY_LEN-1:0]  r_key  [NR_ENTRY];
    logic [DATA_LEN-1:0] r_data [NR_ENTRY];
    logic [IDX_LEN-1:0]  r_rr_ptr;
    logic [IDX_LEN:0]    r_count;

    // Response registers
    logic                r_rsp_valid;
    logic                r_rsp_hit;
    logic [KEY_LEN-1:0]  r_rsp_key;
    logic [IDX_LEN-1:0]  r_rsp_idx;

    // Handshake wires
    logic                w_wr_fire;
    logic                w_wr_en;
    logic                w_lk_fire;

    // Write target selection
    logic                w_key_found;
    logic [IDX_LEN-1:0]  w_key_idx;
    logic                w_free_found;
    logic [IDX_LEN-1:0]  w_free_idx;
    logic                w_replace;
    logic [IDX_LEN-1:0]  w_wr_idx;
    logic [NR_ENTRY-1:0] w_valid_nxt;
    logic [IDX_LEN:0]    w_count_nxt;

    // Lookup match
    logic                w_lk_hit;
    logic [KEY_LEN-1:0]  w_lk_key;
    logic [IDX_LEN-1:0]  w_lk_idx;

    // Both ready signals are forced low while reset is asserted.
    assign wr_ready  = !rst;
    assign lk_ready  = !rst && (!r_rsp_valid || rsp_ready);
    assign w_wr_fire = wr_valid && wr_ready;
    // A write coinciding with flush is accepted but discarded.
    assign w_wr_en   = w_wr_fire && !flush;
    assign w_lk_fire = lk_valid && lk_ready;

    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_key   = r_rsp_key;
    assign rsp_idx   = r_rsp_idx;
    assign count     = r_count;

    // Pick the write slot: existing key, else lowest free entry, else rr_ptr
    always_comb begin
        w_key_found  = 1'b0;
        w_key_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        // Scanning from the top down leaves the lowest matching index last.
        for (int i = NR_ENTRY - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_key[i] == wr_key)) begin
                w_key_found = 1'b1;
                w_key_idx   = IDX_LEN'(i);
            end
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_LEN'(i);
            end
        end
        w_replace = !w_key_found && !w_free_found;
        if (w_key_found) begin
            w_wr_idx = w_key_idx;
        end else if (w_free_found) begin
            w_wr_idx = w_free_idx;
        end else begin
            w_wr_idx = r_rr_ptr;
        end
    end

    // Next valid vector and its popcount, so count stays in step with r_valid
    always_comb begin
        w_valid_nxt = r_valid;
        if (flush) begin
            w_valid_nxt = '0;
        end else if (w_wr_en) begin
            w_valid_nxt[w_wr_idx] = 1'b1;
        end
        w_count_nxt = '0;
        for (int i = 0; i < NR_ENTRY; i++) begin
            w_count_nxt = w_count_nxt + (IDX_LEN + 1)'(w_valid_nxt[i]);
        end
    end

    // Priority-encoded search of lk_data over the valid entries
    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_key = '0;
        w_lk_idx = '0;
        for (int i = NR_ENTRY - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_data[i] == lk_data)) begin
                w_lk_hit = 1'b1;
                w_lk_key = r_key[i];
                w_lk_idx = IDX_LEN'(i);
            end
        end
    end

    // Valid bits, occupancy count and replacement pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            if (flush) begin
                r_rr_ptr <= '0;
            end else if (w_wr_en && w_replace) begin
                // Power-of-two depth makes the natural overflow the wrap.
                r_rr_ptr <= r_rr_ptr + IDX_LEN'(1);
            end
        end
    end

    // Key/data payload; no reset needed because valid bits gate every use
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_key[w_wr_idx]  <= wr_key;
            r_data[w_wr_idx] <= wr_data;
        end
    end

    // Registered response: load on accept, drop valid once consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_key   <= '0;
            r_rsp_idx   <= '0;
        end else if (w_lk_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= w_lk_hit;
            r_rsp_key   <= w_lk_key;
            r_rsp_idx   <= w_lk_idx;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_rev_lookup.sv
// Directed testbench for ysyx_23060061_rev_lookup: a vector table of
// write/lookup/flush operations with expected outputs, followed by
// backpressure and mid-operation reset sequences.
module tb_ysyx_23060061_rev_lookup;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_key;
    logic [31:0] wr_data;
    logic        lk_valid;
    logic        lk_ready;
    logic [31:0] lk_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [3:0]  rsp_key;
    logic [1:0]  rsp_idx;
    logic [2:0]  count;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        wr;
        logic [3:0]  wk;
        logic [31:0] wd;
        logic        lk;
        logic [31:0] ld;
        logic        fl;
        logic        eh;
        logic [3:0]  ek;
        logic [1:0]  ei;
        logic [2:0]  ec;
    } vec_t;

    vec_t tbl [64];
    int   n_vec;

    ysyx_23060061_rev_lookup dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_key    (wr_key),
        .wr_data   (wr_data),
        .lk_valid  (lk_valid),
        .lk_ready  (lk_ready),
        .lk_data   (lk_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_key   (rsp_key),
        .rsp_idx   (rsp_idx),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [3:0] wk, input logic [31:0] wd,
                       input logic lk, input logic [31:0] ld, input logic fl,
                       input logic eh, input logic [3:0] ek, input logic [1:0] ei,
                       input logic [2:0] ec);
        tbl[n_vec].wr = wr;
        tbl[n_vec].wk = wk;
        tbl[n_vec].wd = wd;
        tbl[n_vec].lk = lk;
        tbl[n_vec].ld = ld;
        tbl[n_vec].fl = fl;
        tbl[n_vec].eh = eh;
        tbl[n_vec].ek = ek;
        tbl[n_vec].ei = ei;
        tbl[n_vec].ec = ec;
        n_vec++;
    endtask

    // Write-only vector: expected count after the edge
    task automatic aw(input logic [3:0] k, input logic [31:0] d, input logic [2:0] c);
        add(1'b1, k, d, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 2'd0, c);
    endtask

    // Lookup-only vector: expected hit/key/idx/count after the edge
    task automatic al(input logic [31:0] d, input logic h, input logic [3:0] k,
                      input logic [1:0] i, input logic [2:0] c);
        add(1'b0, 4'h0, 32'h0, 1'b1, d, 1'b0, h, k, i, c);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        n_vec     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        wr_valid  = 1'b0;
        wr_key    = 4'h0;
        wr_data   = 32'h0;
        lk_valid  = 1'b0;
        lk_data   = 32'h0;
        rsp_ready = 1'b1;

        // Table: expected state after each single-cycle vector
        aw(4'd1, 32'h8000_0000, 3'd1);                  // e0
        al(32'h8000_0000, 1'b1, 4'd1, 2'd0, 3'd1);
        aw(4'd2, 32'h0000_2222, 3'd2);                  // e1
        aw(4'd3, 32'h0000_3333, 3'd3);                  // e2
        aw(4'd4, 32'h0000_4444, 3'd4);                  // e3
        al(32'h0000_4444, 1'b1, 4'd4, 2'd3, 3'd4);
        aw(4'd5, 32'h0000_5555, 3'd4);                  // replace e0, rr->1
        aw(4'd6, 32'h0000_6666, 3'd4);                  // replace e1, rr->2
        aw(4'd7, 32'h0000_7777, 3'd4);                  // replace e2, rr->3
        al(32'h8000_0000, 1'b0, 4'd0, 2'd0, 3'd4);      // key 1 evicted
        al(32'h0000_6666, 1'b1, 4'd6, 2'd1, 3'd4);
        aw(4'd5, 32'h0000_AAAA, 3'd4);                  // key hit on e0, rr stays 3
        al(32'h0000_5555, 1'b0, 4'd0, 2'd0, 3'd4);
        al(32'h0000_AAAA, 1'b1, 4'd5, 2'd0, 3'd4);
        aw(4'd8, 32'h0000_8888, 3'd4);                  // replace e3, rr->0
        al(32'h0000_8888, 1'b1, 4'd8, 2'd3, 3'd4);
        al(32'h0000_4444, 1'b0, 4'd0, 2'd0, 3'd4);
        aw(4'd9, 32'h0000_9999, 3'd4);                  // replace e0, rr->1
        al(32'h0000_AAAA, 1'b0, 4'd0, 2'd0, 3'd4);
        al(32'h0000_9999, 1'b1, 4'd9, 2'd0, 3'd4);
        aw(4'd10, 32'h0000_8888, 3'd4);                 // replace e1 with duplicate data
        al(32'h0000_8888, 1'b1, 4'd10, 2'd1, 3'd4);     // lowest of e1/e3
        // write and lookup of the same data in one cycle: lookup sees old contents
        add(1'b1, 4'd11, 32'h0000_BBBB, 1'b1, 32'h0000_BBBB, 1'b0, 1'b0, 4'd0, 2'd0, 3'd4);
        al(32'h0000_BBBB, 1'b1, 4'd11, 2'd2, 3'd4);     // e2, rr->3
        // flush + lookup + write together: lookup hits, write dropped
        add(1'b1, 4'd12, 32'h0000_CCCC, 1'b1, 32'h0000_9999, 1'b1, 1'b1, 4'd9, 2'd0, 3'd0);
        al(32'h0000_9999, 1'b0, 4'd0, 2'd0, 3'd0);
        al(32'h0000_CCCC, 1'b0, 4'd0, 2'd0, 3'd0);
        aw(4'd2, 32'h0000_000A, 3'd1);                  // e0
        aw(4'd2, 32'h0000_000B, 3'd1);                  // overwrite e0
        al(32'h0000_000A, 1'b0, 4'd0, 2'd0, 3'd1);
        al(32'h0000_000B, 1'b1, 4'd2, 2'd0, 3'd1);
        aw(4'd3, 32'h0000_0003, 3'd2);                  // e1
        aw(4'd4, 32'h0000_0004, 3'd3);                  // e2
        aw(4'd5, 32'h0000_0005, 3'd4);                  // e3
        aw(4'd6, 32'h0000_0006, 3'd4);                  // flush reset rr: replaces e0
        al(32'h0000_0006, 1'b1, 4'd6, 2'd0, 3'd4);

        // Reset state
        @(posedge clk);
        #1;
        check("rst.wr_ready", 32'(wr_ready), 32'd0);
        check("rst.lk_ready", 32'(lk_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst.wr_ready", 32'(wr_ready), 32'd1);
        check("post_rst.lk_ready", 32'(lk_ready), 32'd1);
        check("post_rst.rsp_hit", 32'(rsp_hit), 32'd0);
        check("post_rst.rsp_key", 32'(rsp_key), 32'd0);
        check("post_rst.rsp_idx", 32'(rsp_idx), 32'd0);

        // Table-driven section, rsp_ready held high
        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk);
            wr_valid = tbl[i].wr;
            wr_key   = tbl[i].wk;
            wr_data  = tbl[i].wd;
            lk_valid = tbl[i].lk;
            lk_data  = tbl[i].ld;
            flush    = tbl[i].fl;
            @(posedge clk);
            #1;
            check($sformatf("v%0d.rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].lk));
            check($sformatf("v%0d.count", i), 32'(count), 32'(tbl[i].ec));
            if (tbl[i].lk) begin
                check($sformatf("v%0d.rsp_hit", i), 32'(rsp_hit), 32'(tbl[i].eh));
                check($sformatf("v%0d.rsp_key", i), 32'(rsp_key), 32'(tbl[i].ek));
                check($sformatf("v%0d.rsp_idx", i), 32'(rsp_idx), 32'(tbl[i].ei));
            end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        lk_valid = 1'b0;
        flush    = 1'b0;
        // Contents now: e0=(6,6) e1=(3,3) e2=(4,4) e3=(5,5)

        // Backpressure: one lookup accepted, a second one held off for 3 cycles
        @(negedge clk);
        rsp_ready = 1'b0;
        lk_valid  = 1'b1;
        lk_data   = 32'h0000_0003;
        @(posedge clk);
        #1;
        check("bp.first_valid", 32'(rsp_valid), 32'd1);
        check("bp.first_key", 32'(rsp_key), 32'd3);
        @(negedge clk);
        lk_data = 32'h0000_0004;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp.hold%0d.lk_ready", c), 32'(lk_ready), 32'd0);
            check($sformatf("bp.hold%0d.rsp_valid", c), 32'(rsp_valid), 32'd1);
            check($sformatf("bp.hold%0d.rsp_key", c), 32'(rsp_key), 32'd3);
            check($sformatf("bp.hold%0d.rsp_idx", c), 32'(rsp_idx), 32'd1);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("bp.release.lk_ready", 32'(lk_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp.second_valid", 32'(rsp_valid), 32'd1);
        check("bp.second_key", 32'(rsp_key), 32'd4);
        check("bp.second_idx", 32'(rsp_idx), 32'd2);
        @(negedge clk);
        lk_data = 32'h0000_0005;
        @(posedge clk);
        #1;
        check("bp.third_valid", 32'(rsp_valid), 32'd1);
        check("bp.third_key", 32'(rsp_key), 32'd5);
        check("bp.third_idx", 32'(rsp_idx), 32'd3);
        @(negedge clk);
        lk_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp.drain_valid", 32'(rsp_valid), 32'd0);
        check("bp.drain_hit_held", 32'(rsp_hit), 32'd1);
        check("bp.drain_key_held", 32'(rsp_key), 32'd5);
        check("bp.drain_idx_held", 32'(rsp_idx), 32'd3);
        check("bp.count", 32'(count), 32'd4);

        // Reset while a response is pending and entries are valid
        @(negedge clk);
        rsp_ready = 1'b0;
        lk_valid  = 1'b1;
        lk_data   = 32'h0000_0006;
        @(posedge clk);
        #1;
        check("mrst.pending_valid", 32'(rsp_valid), 32'd1);
        check("mrst.pending_key", 32'(rsp_key), 32'd6);
        @(negedge clk);
        lk_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check("mrst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst.rsp_hit", 32'(rsp_hit), 32'd0);
        check("mrst.rsp_key", 32'(rsp_key), 32'd0);
        check("mrst.count", 32'(count), 32'd0);
        check("mrst.wr_ready", 32'(wr_ready), 32'd0);
        check("mrst.lk_ready", 32'(lk_ready), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        lk_valid  = 1'b1;
        lk_data   = 32'h0000_0006;
        @(posedge clk);
        #1;
        check("mrst.after_valid", 32'(rsp_valid), 32'd1);
        check("mrst.after_hit", 32'(rsp_hit), 32'd0);
        check("mrst.after_key", 32'(rsp_key), 32'd0);
        check("mrst.after_count", 32'(count), 32'd0);
        @(negedge clk);
        lk_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
